// File: rtl/dot_scanner.sv
`default_nettype none
// ============================================================================
// dot_scanner - self-timed row scanner for an LED matrix with double-buffered
// frames; define DIM_EN for a per-row brightness input.  Rev 1.0
// ============================================================================
module dot_scanner #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DIV   = 1024,
  parameter int BLANK = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
`ifdef DIM_EN
  input  logic [$clog2(DIV)-1:0]    bright,
`endif
  input  logic [ROWS*COLS-1:0]      frame_d,
  input  logic                      frame_vld,
  output logic                      frame_rdy,
  output logic [COLS-1:0]           col_q,
  output logic [ROWS-1:0]           row_sel,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic                      frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(DIV);
  localparam int FW = ROWS * COLS;

  localparam logic [TW-1:0] c_TICK_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0] c_BLANK_LAST = TW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic [RW-1:0] c_ROW_LAST   = RW'(ROWS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  localparam logic [0:0] ST_RESET = (BLANK > 0) ? ST_BLANK : ST_SHOW;

  logic [TW-1:0]   tick_q, tick_d;
  logic [RW-1:0]   row_q, row_d;
  logic [0:0]      state_q, state_d;
  logic [FW-1:0]   active_q, pend_q;
  logic            pend_full_q;
  logic            swap_dly_q;

  logic [COLS-1:0] col_d;
  logic [ROWS-1:0] row_sel_d;
  logic [RW-1:0]   row_idx_d;
  logic            frame_start_d;

  logic            w_dwell_end, w_frame_wrap, w_swap, w_xfer, w_lit;
  logic [COLS-1:0] w_rows [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_rows
    assign w_rows[r] = active_q[r*COLS +: COLS];
  end

  assign w_dwell_end  = en & (tick_q == c_TICK_LAST);
  assign w_frame_wrap = w_dwell_end & (row_q == c_ROW_LAST);
  assign w_swap       = w_frame_wrap & pend_full_q;
  assign frame_rdy    = ~pend_full_q | w_swap;
  assign w_xfer       = frame_vld & frame_rdy;

  always_comb begin
    tick_d = tick_q;
    row_d  = row_q;
    if (en) begin
      tick_d = w_dwell_end ? '0 : tick_q + 1'b1;
      if (w_dwell_end) begin
        row_d = w_frame_wrap ? '0 : row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      row_q  <= '0;
    end else begin
      tick_q <= tick_d;
      row_q  <= row_d;
    end
  end

  // A transfer on the swap cycle refills pending, so pend_full stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      swap_dly_q  <= 1'b0;
    end else begin
      if (w_swap) begin
        active_q <= pend_q;
      end
      if (w_xfer) begin
        pend_q      <= frame_d;
        pend_full_q <= 1'b1;
      end else if (w_swap) begin
        pend_full_q <= 1'b0;
      end
      swap_dly_q <= w_swap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_BLANK: if (tick_q == c_BLANK_LAST) state_d = ST_SHOW;
        ST_SHOW:  if (w_dwell_end && (BLANK > 0)) state_d = ST_BLANK;
        default:  state_d = ST_RESET;
      endcase
    end
  end

`ifdef DIM_EN
  localparam logic [TW:0] c_BLANK_W = (TW+1)'(BLANK);

  logic [TW-1:0] bright_q;
  logic [TW-1:0] w_bright;

  // The row's brightness is taken live on tick 0 and held for the rest of it.
  assign w_bright = (tick_q == '0) ? bright : bright_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= '0;
    end else if (en && (tick_q == '0)) begin
      bright_q <= bright;
    end
  end

  assign w_lit = en & (state_q == ST_SHOW) &
                 (({1'b0, tick_q} - c_BLANK_W) < {1'b0, w_bright});
`else
  assign w_lit = en & (state_q == ST_SHOW);
`endif

  always_comb begin
    col_d         = '0;
    row_sel_d     = '0;
    row_idx_d     = row_q;
    frame_start_d = swap_dly_q;
    if (w_lit) begin
      col_d     = w_rows[row_q];
      row_sel_d = ROWS'(1) << row_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_sel     <= '0;
      row_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_sel     <= row_sel_d;
      row_idx     <= row_idx_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_scanner.sv
`default_nettype none
// ============================================================================
// tb_dot_scanner - directed and randomized checks of dot_scanner against a
// position-counting reference model.  Rev 1.0
// ============================================================================
module tb_dot_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int RW    = $clog2(ROWS);
  localparam int TW    = $clog2(DIV);
  localparam int FW    = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst, en, frame_vld;
  logic [FW-1:0]   frame_d;
  logic            frame_rdy, frame_start;
  logic [COLS-1:0] col_q;
  logic [ROWS-1:0] row_sel;
  logic [RW-1:0]   row_idx;
`ifdef DIM_EN
  logic [TW-1:0]   bright;
`endif

  dot_scanner #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
`ifdef DIM_EN
    .bright      (bright),
`endif
    .frame_d     (frame_d),
    .frame_vld   (frame_vld),
    .frame_rdy   (frame_rdy),
    .col_q       (col_q),
    .row_sel     (row_sel),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: scan position is a single count of enabled cycles.
  int unsigned     m_pos, m_t, m_r, m_bright;
  logic [FW-1:0]   m_act, m_pend;
  bit              m_pfull, m_fs_next, m_lit, m_wrap, m_rdy, m_sw, armed;
  logic [COLS-1:0] e_col;
  logic [ROWS-1:0] e_sel;
  logic [RW-1:0]   e_idx;
  bit              e_fs, e_rdy;

  initial begin
    armed = 0;
    m_pos = 0; m_act = '0; m_pend = '0; m_pfull = 0; m_fs_next = 0; m_bright = 0;
    e_col = '0; e_sel = '0; e_idx = '0; e_fs = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        armed = 1;
        m_pos = 0; m_act = '0; m_pend = '0; m_pfull = 0; m_fs_next = 0; m_bright = 0;
        e_col = '0; e_sel = '0; e_idx = '0; e_fs = 0;
      end else begin
        m_t   = m_pos % DIV;
        m_r   = (m_pos / DIV) % ROWS;
        m_lit = en && (m_t >= BLANK);
`ifdef DIM_EN
        if (m_t == 0) m_bright = bright;
        m_lit = m_lit && ((m_t - BLANK) < m_bright);
`endif
        e_col = m_lit ? COLS'(m_act >> (m_r * COLS)) : '0;
        e_sel = m_lit ? ROWS'(1 << m_r) : '0;
        e_idx = RW'(m_r);
        e_fs  = m_fs_next;
        m_wrap = en && (m_t == DIV - 1) && (m_r == ROWS - 1);
        m_sw   = m_wrap && m_pfull;
        m_rdy  = !m_pfull || m_sw;
        if (m_sw) m_act = m_pend;
        m_fs_next = m_sw;
        if (frame_vld && m_rdy) begin
          m_pend  = frame_d;
          m_pfull = 1;
        end else if (m_sw) begin
          m_pfull = 0;
        end
        if (en) m_pos = (m_pos + 1) % (ROWS * DIV);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        e_rdy = !m_pfull || (en && (m_pos % DIV == DIV - 1) &&
                             ((m_pos / DIV) % ROWS == ROWS - 1));
        chk("col_q", col_q, e_col);
        chk("row_sel", row_sel, e_sel);
        chk("row_idx", row_idx, e_idx);
        chk("frame_start", frame_start, e_fs);
        chk("frame_rdy", frame_rdy, e_rdy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit              found, took;
  logic [COLS-1:0] col_or;

  initial begin
    rst = 1'b1; en = 1'b1; frame_vld = 1'b0; frame_d = '0;
`ifdef DIM_EN
    bright = TW'(DIV - 1);
`endif
    cyc(); cyc();
    chk("reset_col", col_q, 0);
    chk("reset_sel", row_sel, 0);
    chk("reset_idx", row_idx, 0);
    chk("reset_rdy", frame_rdy, 1);

    // Load the counting frame; it appears only after the first wrap.
    rst = 1'b0; frame_d = 64'h0807060504030201; frame_vld = 1'b1;
    cyc();
    frame_vld = 1'b0;
    chk("rdy_after_load", frame_rdy, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (frame_start) found = 1;
    end
    chk("first_frame_start_seen", found, 1);
    chk("fs_row_idx", row_idx, 0);
    chk("fs_blank_col", col_q, 0);
    repeat (13) cyc();
    chk("row3_col", col_q, 8'h04);
    chk("row3_sel", row_sel, 8'h08);

    // Back-to-back frames A then B.
    frame_d = 64'h1122334455667788; frame_vld = 1'b1;
    cyc();
    frame_d = 64'hA0B0C0D0E0F01020;
    chk("rdy_drop_after_A", frame_rdy, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (frame_rdy) found = 1;
    end
    chk("rdy_rise_at_wrap", found, 1);
    cyc();
    frame_vld = 1'b0;
    chk("B_held_in_pending", frame_rdy, 0);
    cyc();
    chk("A_frame_start", frame_start, 1);
    cyc();
    chk("A_row0_col", col_q, 8'h88);
    chk("A_row0_sel", row_sel, 8'h01);

    // Pause mid-row 3.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (row_idx == 3 && row_sel != 0) found = 1;
    end
    chk("reach_row3", found, 1);
    en = 1'b0;
    repeat (10) cyc();
    chk("pause_col", col_q, 0);
    chk("pause_sel", row_sel, 0);
    chk("pause_idx", row_idx, 3);
    en = 1'b1;
    cyc();
    chk("resume_col", col_q, 8'h55);
    chk("resume_idx", row_idx, 3);

    // Reset mid-row 5 while B is still pending.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (row_idx == 5) found = 1;
    end
    chk("reach_row5", found, 1);
    rst = 1'b1;
    cyc();
    chk("midrst_col", col_q, 0);
    chk("midrst_sel", row_sel, 0);
    chk("midrst_rdy", frame_rdy, 1);
    rst = 1'b0;
    col_or = '0;
    repeat (40) begin
      cyc();
      col_or = col_or | col_q;
    end
    chk("no_stale_frame", col_or, 0);

    // Randomized traffic.
    took = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if (rst || !frame_vld || took) begin
        frame_vld = ($urandom_range(0, 3) == 0);
        frame_d   = FW'({$urandom, $urandom});
      end
`ifdef DIM_EN
      if ($urandom_range(0, 7) == 0) bright = TW'($urandom);
`endif
      #1;
      took = frame_vld && frame_rdy && !rst;
      cyc();
    end
    rst = 1'b0; frame_vld = 1'b0; en = 1'b1;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
